// File: rtl/branch_seq_if.sv
// Interface bundling the branch sequencer's handshake, inputs and strobes.
// The master side is the control unit that requests a sequence. The slave
// side is the sequencer, which drives the datapath strobes.
interface branch_seq_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             stall;
  logic [31:0]      ir;
  logic             con_out;
  logic             gra;
  logic             r_out;
  logic             con_in;
  logic             pc_out;
  logic             y_in;
  logic             c_out;
  logic             alu_add;
  logic             z_in;
  logic             zlo_out;
  logic             pc_in;
  logic             busy;
  logic             done;
  logic             taken;
  logic             illegal;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output start, stall, ir, con_out,
    input  gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, zlo_out,
           pc_in, busy, done, taken, illegal, taken_cnt
  );

  modport slave (
    input  start, stall, ir, con_out,
    output gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, zlo_out,
           pc_in, busy, done, taken, illegal, taken_cnt
  );
endinterface

// File: rtl/branch_seq.sv
// branch_seq: execute-phase sequencer for conditional branches (T3..T6).
// Steps: Ra onto the bus with CON load, PC into Y, PC+C into Z, then Zlow
// into PC only when the latched condition held. Hands back via done/taken.
// Optional feature macro BRANCH_SKIP_EN: a not-taken branch jumps from T4
// straight to FIN, skipping the address computation.
module branch_seq #(
  parameter logic [4:0] OPC_BR = 5'b10010,
  parameter int         CNT_W  = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  branch_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T3   = 3'd1,
    T4   = 3'd2,
    T5   = 3'd3,
    T6   = 3'd4,
    FIN  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             con_q;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;

  logic gra_c, r_out_c, con_in_c, pc_out_c, y_in_c, c_out_c;
  logic alu_add_c, z_in_c, zlo_out_c, pc_in_c, done_c, taken_c;
  logic is_br;

  assign is_br = (bus.ir[31:27] == OPC_BR);

  // Next-state and strobe decode; stall freezes the state and gates every strobe.
  always_comb begin
    state_d   = state_q;
    gra_c     = 1'b0;
    r_out_c   = 1'b0;
    con_in_c  = 1'b0;
    pc_out_c  = 1'b0;
    y_in_c    = 1'b0;
    c_out_c   = 1'b0;
    alu_add_c = 1'b0;
    z_in_c    = 1'b0;
    zlo_out_c = 1'b0;
    pc_in_c   = 1'b0;
    done_c    = 1'b0;
    taken_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && is_br) state_d = T3;
      end
      T3: begin
        gra_c    = 1'b1;
        r_out_c  = 1'b1;
        con_in_c = 1'b1;
        state_d  = T4;
      end
      T4: begin
        pc_out_c = 1'b1;
        y_in_c   = 1'b1;
`ifdef BRANCH_SKIP_EN
        state_d  = bus.con_out ? T5 : FIN;
`else
        state_d  = T5;
`endif
      end
      T5: begin
        c_out_c   = 1'b1;
        alu_add_c = 1'b1;
        z_in_c    = 1'b1;
        state_d   = T6;
      end
      T6: begin
        zlo_out_c = 1'b1;
        pc_in_c   = con_q;
        state_d   = FIN;
      end
      FIN: begin
        done_c  = 1'b1;
        taken_c = con_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.stall) begin
      state_d   = state_q;
      gra_c     = 1'b0;
      r_out_c   = 1'b0;
      con_in_c  = 1'b0;
      pc_out_c  = 1'b0;
      y_in_c    = 1'b0;
      c_out_c   = 1'b0;
      alu_add_c = 1'b0;
      z_in_c    = 1'b0;
      zlo_out_c = 1'b0;
      pc_in_c   = 1'b0;
      done_c    = 1'b0;
      taken_c   = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Capture CON at the end of T4 so later CON changes cannot alter the decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              con_q <= 1'b0;
    else if (state_q == T4 && !bus.stall)    con_q <= bus.con_out;
  end

  // Flag a non-branch opcode presented to an idle sequencer, one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= (state_q == IDLE) && bus.start && !bus.stall && !is_br;
  end

  // Saturating taken-branch counter, bumped on the cycle done is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 cnt_q <= '0;
    else if (done_c && con_q && (cnt_q != '1))  cnt_q <= cnt_q + CNT_W'(1);
  end

  assign bus.gra       = gra_c;
  assign bus.r_out     = r_out_c;
  assign bus.con_in    = con_in_c;
  assign bus.pc_out    = pc_out_c;
  assign bus.y_in      = y_in_c;
  assign bus.c_out     = c_out_c;
  assign bus.alu_add   = alu_add_c;
  assign bus.z_in      = z_in_c;
  assign bus.zlo_out   = zlo_out_c;
  assign bus.pc_in     = pc_in_c;
  assign bus.done      = done_c;
  assign bus.taken     = taken_c;
  assign bus.busy      = (state_q != IDLE);
  assign bus.illegal   = illegal_q;
  assign bus.taken_cnt = cnt_q;

endmodule

// File: tb/tb_branch_seq.sv
// Testbench for branch_seq: per-cycle vector table on a 16-bit-counter
// instance, hand-written reset-mid-sequence check, and a 2-bit-counter
// instance for saturation.
module tb_branch_seq;

  localparam logic [4:0] OPC_BR  = 5'b10010;
  localparam logic [4:0] OPC_BAD = 5'b00011;

  // Output vector bit order:
  // gra r_out con_in pc_out y_in c_out alu_add z_in zlo_out pc_in busy done taken illegal
  localparam logic [13:0] O_IDLE  = 14'b00000000000000;
  localparam logic [13:0] O_T3    = 14'b11100000001000;
  localparam logic [13:0] O_T4    = 14'b00011000001000;
  localparam logic [13:0] O_T5    = 14'b00000111001000;
  localparam logic [13:0] O_T6N   = 14'b00000000101000;
  localparam logic [13:0] O_T6T   = 14'b00000000111000;
  localparam logic [13:0] O_FIN_T = 14'b00000000001110;
  localparam logic [13:0] O_FIN_N = 14'b00000000001100;
  localparam logic [13:0] O_BUSY  = 14'b00000000001000;
  localparam logic [13:0] O_ILL   = 14'b00000000000001;

  typedef struct {
    logic        start;
    logic        stall;
    logic        con;
    logic [4:0]  op;
    logic [13:0] exp_o;
    logic [15:0] exp_cnt;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  vec_t tbl[$];

  branch_seq_if #(.CNT_W(16)) m_if ();
  branch_seq_if #(.CNT_W(2))  s_if ();

  branch_seq #(.OPC_BR(OPC_BR), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m_if.slave)
  );

  branch_seq #(.OPC_BR(OPC_BR), .CNT_W(2)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (s_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] outv();
    return {m_if.gra, m_if.r_out, m_if.con_in, m_if.pc_out, m_if.y_in,
            m_if.c_out, m_if.alu_add, m_if.z_in, m_if.zlo_out, m_if.pc_in,
            m_if.busy, m_if.done, m_if.taken, m_if.illegal};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic st, input logic sl, input logic cn,
                     input logic [4:0] op, input logic [13:0] eo, input logic [15:0] ec);
    vec_t v;
    v.start = st; v.stall = sl; v.con = cn; v.op = op; v.exp_o = eo; v.exp_cnt = ec;
    tbl.push_back(v);
  endtask

  task automatic drive_m(input logic st, input logic sl, input logic cn, input logic [4:0] op);
    m_if.start   = st;
    m_if.stall   = sl;
    m_if.con_out = cn;
    m_if.ir      = {op, 4'd0, 4'b0000, 19'd0};
  endtask

  task automatic sat_branch();
    @(posedge clk); #1;
    s_if.start = 1'b1;
    @(posedge clk); #1;
    s_if.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    drive_m(1'b0, 1'b0, 1'b0, OPC_BR);
    s_if.start   = 1'b0;
    s_if.stall   = 1'b0;
    s_if.con_out = 1'b1;
    s_if.ir      = {OPC_BR, 27'd0};

    // Taken branch; start held in FIN must not be accepted.
    add(1, 0, 0, OPC_BR, O_IDLE,  16'd0);
    add(0, 0, 1, OPC_BR, O_T3,    16'd0);
    add(0, 0, 1, OPC_BR, O_T4,    16'd0);
    add(0, 0, 0, OPC_BR, O_T5,    16'd0);
    add(0, 0, 0, OPC_BR, O_T6T,   16'd0);
    add(1, 0, 0, OPC_BR, O_FIN_T, 16'd0);
    add(0, 0, 0, OPC_BR, O_IDLE,  16'd1);
    // Not-taken branch; CON rising after T4 must not change the decision.
    add(1, 0, 0, OPC_BR, O_IDLE,  16'd1);
    add(0, 0, 0, OPC_BR, O_T3,    16'd1);
    add(0, 0, 0, OPC_BR, O_T4,    16'd1);
`ifdef BRANCH_SKIP_EN
    add(0, 0, 1, OPC_BR, O_FIN_N, 16'd1);
    add(0, 0, 1, OPC_BR, O_IDLE,  16'd1);
    add(0, 0, 0, OPC_BR, O_IDLE,  16'd1);
    add(0, 0, 0, OPC_BR, O_IDLE,  16'd1);
`else
    add(0, 0, 1, OPC_BR, O_T5,    16'd1);
    add(0, 0, 1, OPC_BR, O_T6N,   16'd1);
    add(0, 0, 0, OPC_BR, O_FIN_N, 16'd1);
    add(0, 0, 0, OPC_BR, O_IDLE,  16'd1);
`endif
    // Two stall cycles in T4; CON low during stall, high when released.
    add(1, 0, 0, OPC_BR, O_IDLE,  16'd1);
    add(0, 0, 0, OPC_BR, O_T3,    16'd1);
    add(0, 1, 0, OPC_BR, O_BUSY,  16'd1);
    add(0, 1, 0, OPC_BR, O_BUSY,  16'd1);
    add(0, 0, 1, OPC_BR, O_T4,    16'd1);
    add(0, 0, 0, OPC_BR, O_T5,    16'd1);
    add(0, 0, 0, OPC_BR, O_T6T,   16'd1);
    add(0, 0, 0, OPC_BR, O_FIN_T, 16'd1);
    add(0, 0, 0, OPC_BR, O_IDLE,  16'd2);
    // Stall in FIN withholds done.
    add(1, 0, 0, OPC_BR, O_IDLE,  16'd2);
    add(0, 0, 0, OPC_BR, O_T3,    16'd2);
    add(0, 0, 1, OPC_BR, O_T4,    16'd2);
    add(0, 0, 0, OPC_BR, O_T5,    16'd2);
    add(0, 0, 0, OPC_BR, O_T6T,   16'd2);
    add(0, 1, 0, OPC_BR, O_BUSY,  16'd2);
    add(0, 0, 0, OPC_BR, O_FIN_T, 16'd2);
    add(0, 0, 0, OPC_BR, O_IDLE,  16'd3);
    // Illegal opcode.
    add(1, 0, 0, OPC_BAD, O_IDLE, 16'd3);
    add(0, 0, 0, OPC_BR,  O_ILL,  16'd3);
    add(0, 0, 0, OPC_BR,  O_IDLE, 16'd3);
    // Starts while busy are ignored (including an illegal opcode).
    add(1, 0, 0, OPC_BR,  O_IDLE,  16'd3);
    add(1, 0, 0, OPC_BAD, O_T3,    16'd3);
    add(1, 0, 1, OPC_BR,  O_T4,    16'd3);
    add(0, 0, 0, OPC_BR,  O_T5,    16'd3);
    add(0, 0, 0, OPC_BR,  O_T6T,   16'd3);
    add(0, 0, 0, OPC_BR,  O_FIN_T, 16'd3);
    add(0, 0, 0, OPC_BR,  O_IDLE,  16'd4);

    // Reset state.
    #3;
    check("reset_out", 32'(outv()), 32'(O_IDLE));
    check("reset_cnt", 32'(m_if.taken_cnt), 32'd0);
    #9 rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      drive_m(tbl[i].start, tbl[i].stall, tbl[i].con, tbl[i].op);
      #4;
      check($sformatf("row%0d_out", i), 32'(outv()), 32'(tbl[i].exp_o));
      check($sformatf("row%0d_cnt", i), 32'(m_if.taken_cnt), 32'(tbl[i].exp_cnt));
    end

    // Asynchronous reset while in T5.
    @(posedge clk); #1; drive_m(1'b1, 1'b0, 1'b0, OPC_BR);
    @(posedge clk); #1; drive_m(1'b0, 1'b0, 1'b1, OPC_BR);
    @(posedge clk); #1;
    @(posedge clk); #1; drive_m(1'b0, 1'b0, 1'b0, OPC_BR);
    check("pre_rst_t5", 32'(outv()), 32'(O_T5));
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out", 32'(outv()), 32'(O_IDLE));
    check("midrst_cnt", 32'(m_if.taken_cnt), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #5;
      check($sformatf("postrst%0d_out", k), 32'(outv()), 32'(O_IDLE));
    end

    // Saturation of a 2-bit counter.
    for (int k = 1; k <= 5; k++) begin
      sat_branch();
      check($sformatf("sat%0d_cnt", k), 32'(s_if.taken_cnt), (k > 3) ? 32'd3 : 32'(k));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
